// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, detects the start edge, samples each bit at
// mid-bit and presents the received byte with a single-cycle po_flag strobe.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [12:0] BAUD_LAST    = 13'(BAUD_CNT_MAX - 1);
  localparam logic [12:0] BAUD_MID     = 13'(BAUD_CNT_MAX / 2 - 1);

  logic        rx_reg1;
  logic        rx_reg2;
  logic        rx_reg3;
  logic        work_en;
  logic [12:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_data;
  logic        rx_flag;

  logic        start_nedge;
  logic        bit_flag;
  logic        start_glitch;
  logic        frame_end;
  logic        data_bit;

  // rx_reg1 is the metastability stage; edge detection uses the two later flops.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_reg1 <= 1'b1;
      rx_reg2 <= 1'b1;
      rx_reg3 <= 1'b1;
    end else begin
      rx_reg1 <= rx;
      rx_reg2 <= rx_reg1;
      rx_reg3 <= rx_reg2;
    end
  end

  always_comb begin
    start_nedge  = ~rx_reg2 & rx_reg3 & ~work_en;
    bit_flag     = work_en & (baud_cnt == BAUD_MID);
    start_glitch = bit_flag & (bit_cnt == 4'd0) & rx_reg3;
    frame_end    = bit_flag & (bit_cnt == 4'd8);
    data_bit     = bit_flag & (bit_cnt >= 4'd1) & (bit_cnt <= 4'd8);
  end

  // Frame ends at the mid-bit of data bit 7, so the stop bit finds us idle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      work_en <= 1'b0;
    end else if (start_glitch || frame_end) begin
      work_en <= 1'b0;
    end else if (start_nedge) begin
      work_en <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      baud_cnt <= 13'd0;
    end else if (!work_en || start_glitch || frame_end || baud_cnt == BAUD_LAST) begin
      baud_cnt <= 13'd0;
    end else begin
      baud_cnt <= baud_cnt + 13'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_cnt <= 4'd0;
    end else if (start_glitch || frame_end) begin
      bit_cnt <= 4'd0;
    end else if (bit_flag) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // LSB arrives first, so shifting in from the top leaves bit 0 at rx_data[0].
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_data <= 8'h00;
    end else if (data_bit) begin
      rx_data <= {rx_reg3, rx_data[7:1]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_flag <= 1'b0;
    end else begin
      rx_flag <= frame_end;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_data <= 8'h00;
      po_flag <= 1'b0;
    end else begin
      po_flag <= rx_flag;
      if (rx_flag) begin
        po_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven in real time, expected bytes queued at
// frame start and matched by an independent monitor against each po_flag strobe.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int      CLK_FREQ = 6_400_000;
  localparam int      UART_BPS = 100_000;
  localparam realtime BIT_NS   = 1280.0;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #10 sys_clk = ~sys_clk;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .rx     (rx),
    .po_data(po_data),
    .po_flag(po_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input realtime bt);
    exp_q.push_back(b);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
    rx = 1'b1;
    #(bt);
  endtask

  // Monitor: every strobe must be one cycle wide and carry the oldest expected byte;
  // between strobes po_data must not move.
  initial begin
    logic [7:0] last_data;
    logic       last_flag;
    logic [7:0] exp;
    last_data = 8'h00;
    last_flag = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_rst) begin
        last_data = 8'h00;
        last_flag = 1'b0;
      end else begin
        if (po_flag) begin
          total++;
          if (last_flag) begin
            bad++;
            $display("FAIL flag_width: po_flag high 2+ cycles, required 1");
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_flag: po_data=%02h, required no strobe", po_data);
          end else begin
            exp = exp_q.pop_front();
            if (po_data !== exp) begin
              bad++;
              $display("FAIL rx_byte: got %02h, required %02h", po_data, exp);
            end else begin
              $display("rx byte %02h (expected %02h)", po_data, exp);
            end
          end
          last_data = po_data;
        end else begin
          total++;
          if (po_data !== last_data) begin
            bad++;
            $display("FAIL data_hold: po_data=%02h, required %02h", po_data, last_data);
          end
        end
        last_flag = po_flag;
      end
    end
  end

  initial begin
    realtime bt;
    rx      = 1'b1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check("reset_po_data", {24'h0, po_data}, 32'h00);
    check("reset_po_flag", {31'h0, po_flag}, 32'h0);
    #(2.0 * BIT_NS);

    // Back-to-back frames, one stop bit each.
    for (int i = 0; i < 8; i++) send_frame(8'(i), BIT_NS);
    #(2.0 * BIT_NS);

    send_frame(8'h55, BIT_NS);
    #(2.0 * BIT_NS);
    send_frame(8'hA5, BIT_NS);
    #(2.0 * BIT_NS);

    // Short low pulse on idle line must be rejected as a false start.
    rx = 1'b0;
    repeat (10) @(posedge sys_clk);
    rx = 1'b1;
    #(3.0 * BIT_NS);
    send_frame(8'h3C, BIT_NS);
    #(2.0 * BIT_NS);

    // Reset in the middle of data bit 4 of an 0xFF frame (nothing expected).
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4.5 * BIT_NS);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    check("midframe_rst_po_data", {24'h0, po_data}, 32'h00);
    check("midframe_rst_po_flag", {31'h0, po_flag}, 32'h0);
    #(4.5 * BIT_NS);
    send_frame(8'h81, BIT_NS);
    #(2.0 * BIT_NS);
    check("after_rst_queue", exp_q.size(), 0);

    // Baud tolerance, slow and fast.
    send_frame(8'hC3, BIT_NS * 0.98);
    #(2.0 * BIT_NS);
    send_frame(8'hC3, BIT_NS * 1.02);
    #(2.0 * BIT_NS);

    // Break: one 0x00 frame, then nothing until rx rises and falls again.
    exp_q.push_back(8'h00);
    rx = 1'b0;
    #(14.0 * BIT_NS);
    rx = 1'b1;
    #(2.0 * BIT_NS);
    send_frame(8'h5A, BIT_NS);

    // Random bytes with +/-2% bit-time jitter and random idle gaps.
    for (int n = 0; n < 24; n++) begin
      bt = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
      send_frame(8'($urandom_range(0, 255)), bt);
      #(real'($urandom_range(0, 2)) * BIT_NS);
    end

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge sys_clk);
    check("drain_queue", exp_q.size(), 0);
    #(3.0 * BIT_NS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
